// File: rtl/sweep_sampler_pkg.sv
// rtl/sweep_sampler_pkg.sv - shared state encoding and address stepping for the sweep sampler
package sweep_sampler_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'b00,
        SAMPLE = 2'b01,
        HOLD   = 2'b10,
        DONE   = 2'b11
    } state_t;

    // Steps an address by one in the given direction, wrapping modulo 2^width.
    // Carried at 64 bits so any address width up to 64 can share one helper.
    function automatic logic [63:0] next_addr(input logic [63:0] cur,
                                              input logic        down,
                                              input int unsigned width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (down ? (cur - 64'd1) : (cur + 64'd1)) & mask;
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// rtl/sweep_hold_timer.sv - loadable down-counter timing the extra cycles spent on one address
module sweep_hold_timer
    import sweep_sampler_pkg::*;
#(
    parameter int HOLD_W = 8
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              load,
    input  logic [HOLD_W-1:0] value,
    output logic              expired
);

    logic [HOLD_W-1:0] count;

    // Load the remaining hold length, then count down and park at zero.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - HOLD_W'(1);
        end
    end

    // A count of one marks the final hold cycle of the current address.
    assign expired = (count == HOLD_W'(1));

endmodule

// File: rtl/sweep_sampler.sv
// rtl/sweep_sampler.sv - address sweep generator with hold, re-sweep, abort; SWEEP_SAMPLER_BIDIR_EN enables down-sweeps
module sweep_sampler
    import sweep_sampler_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int HOLD_W = 8,
    parameter int PASS_W = 8
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iStartSignal,
    input  logic              iAbort,
    input  logic [ADDR_W-1:0] iStartAddr,
    input  logic [ADDR_W-1:0] iEndAddr,
    input  logic [HOLD_W-1:0] iHoldCycles,
    input  logic              iContinuous,
    output logic [ADDR_W-1:0] oAddress,
    output logic              oSampleStrobe,
    output logic              oBusy,
    output logic              oFinished,
    output logic [PASS_W-1:0] oPassCount
);

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic [HOLD_W-1:0] hold_q;
    logic              down_q;
    logic              down_d;

    logic [ADDR_W-1:0] addr_d;
    logic              cfg_load;
    logic              timer_load;
    logic              timer_expired;
    logic              advance;
    logic              pass_inc;

`ifdef SWEEP_SAMPLER_BIDIR_EN
    assign down_d = (iEndAddr < iStartAddr);
`else
    assign down_d = 1'b0;
`endif

    sweep_hold_timer #(
        .HOLD_W (HOLD_W)
    ) u_hold_timer (
        .iClock  (iClock),
        .iReset  (iReset),
        .load    (timer_load),
        .value   (hold_q - HOLD_W'(1)),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, next address and datapath strobes; abort overrides everything.
    always_comb begin
        state_next = state;
        addr_d     = oAddress;
        cfg_load   = 1'b0;
        timer_load = 1'b0;
        advance    = 1'b0;
        pass_inc   = 1'b0;

        case (state)
            IDLE: begin
                if (iStartSignal) begin
                    state_next = SAMPLE;
                    addr_d     = iStartAddr;
                    cfg_load   = 1'b1;
                end
            end
            SAMPLE: begin
                if (hold_q > HOLD_W'(1)) begin
                    state_next = HOLD;
                    timer_load = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            HOLD: begin
                if (timer_expired) begin
                    advance = 1'b1;
                end
            end
            DONE: begin
                if (iContinuous) begin
                    state_next = SAMPLE;
                    addr_d     = start_q;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (advance) begin
            if (oAddress == end_q) begin
                state_next = DONE;
            end else begin
                state_next = SAMPLE;
                addr_d     = ADDR_W'(next_addr(64'(oAddress), down_q, ADDR_W));
            end
        end

        if (iAbort && (state != IDLE)) begin
            state_next = IDLE;
            addr_d     = oAddress;
            timer_load = 1'b0;
        end

        pass_inc = (state_next == DONE);
    end

    // Registered outputs follow the next state; configuration latches on start.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            oAddress      <= '0;
            oSampleStrobe <= 1'b0;
            oBusy         <= 1'b0;
            oFinished     <= 1'b0;
            oPassCount    <= '0;
            start_q       <= '0;
            end_q         <= '0;
            hold_q        <= HOLD_W'(1);
            down_q        <= 1'b0;
        end else begin
            oAddress      <= addr_d;
            oSampleStrobe <= (state_next == SAMPLE);
            oBusy         <= (state_next != IDLE);
            oFinished     <= (state_next == DONE);
            if (cfg_load) begin
                start_q    <= iStartAddr;
                end_q      <= iEndAddr;
                hold_q     <= (iHoldCycles == '0) ? HOLD_W'(1) : iHoldCycles;
                down_q     <= down_d;
                oPassCount <= '0;
            end else if (pass_inc && (oPassCount != '1)) begin
                oPassCount <= oPassCount + PASS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sweep_sampler.sv
// tb/tb_sweep_sampler.sv - directed self-checking bench for sweep_sampler
module tb_sweep_sampler;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iStartSignal;
    logic        iAbort;
    logic [15:0] iStartAddr;
    logic [15:0] iEndAddr;
    logic [7:0]  iHoldCycles;
    logic        iContinuous;
    logic [15:0] oAddress;
    logic        oSampleStrobe;
    logic        oBusy;
    logic        oFinished;
    logic [7:0]  oPassCount;

    int total = 0;
    int bad   = 0;

    always #5 iClock = ~iClock;

    sweep_sampler dut (
        .iClock        (iClock),
        .iReset        (iReset),
        .iStartSignal  (iStartSignal),
        .iAbort        (iAbort),
        .iStartAddr    (iStartAddr),
        .iEndAddr      (iEndAddr),
        .iHoldCycles   (iHoldCycles),
        .iContinuous   (iContinuous),
        .oAddress      (oAddress),
        .oSampleStrobe (oSampleStrobe),
        .oBusy         (oBusy),
        .oFinished     (oFinished),
        .oPassCount    (oPassCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic start_sweep(input logic [15:0] s, input logic [15:0] e,
                               input logic [7:0] h, input logic c);
        iStartAddr   = s;
        iEndAddr     = e;
        iHoldCycles  = h;
        iContinuous  = c;
        iStartSignal = 1'b1;
        tick();
        iStartSignal = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [15:0] ea;
        int          nmis;

        iReset       = 1'b1;
        iStartSignal = 1'b0;
        iAbort       = 1'b0;
        iStartAddr   = '0;
        iEndAddr     = '0;
        iHoldCycles  = '0;
        iContinuous  = 1'b0;
        tick();
        tick();
        iReset = 1'b0;
        check("rst_addr", oAddress, 0);
        check("rst_strobe", oSampleStrobe, 0);
        check("rst_busy", oBusy, 0);
        check("rst_fin", oFinished, 0);
        check("rst_pass", oPassCount, 0);

        // 0x10..0x13, one cycle each
        start_sweep(16'h0010, 16'h0013, 8'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", oAddress, 32'h10 + i);
            check("t1_strobe", oSampleStrobe, 1);
            check("t1_fin", oFinished, 0);
            tick();
        end
        check("t1_done_fin", oFinished, 1);
        check("t1_done_busy", oBusy, 1);
        check("t1_done_pass", oPassCount, 1);
        tick();
        check("t1_idle_busy", oBusy, 0);
        check("t1_idle_fin", oFinished, 0);
        check("t1_idle_addr", oAddress, 16'h0013);

        // 5..6 held three cycles each
        start_sweep(16'd5, 16'd6, 8'd3, 1'b0);
        for (int c = 0; c < 6; c++) begin
            check("t2_addr", oAddress, 5 + c / 3);
            check("t2_strobe", oSampleStrobe, (c % 3 == 0) ? 1 : 0);
            check("t2_fin", oFinished, 0);
            tick();
        end
        check("t2_done_fin", oFinished, 1);
        check("t2_done_pass", oPassCount, 1);
        tick();
        check("t2_idle_busy", oBusy, 0);

        // FFFE -> 0001 with hold 0 treated as 1
        start_sweep(16'hFFFE, 16'h0001, 8'd0, 1'b0);
`ifdef SWEEP_SAMPLER_BIDIR_EN
        nmis = 0;
        for (int i = 0; i < 65534; i++) begin
            ea = 16'hFFFE - 16'(i);
            if (i < 3 || i > 65531) begin
                check("t3_down_addr", oAddress, ea);
                check("t3_down_strobe", oSampleStrobe, 1);
            end else if (oAddress !== ea || oSampleStrobe !== 1'b1) begin
                nmis++;
            end
            tick();
        end
        check("t3_down_mid_mismatches", nmis, 0);
`else
        for (int i = 0; i < 4; i++) begin
            ea = 16'hFFFE + 16'(i);
            check("t3_wrap_addr", oAddress, ea);
            check("t3_wrap_strobe", oSampleStrobe, 1);
            tick();
        end
`endif
        check("t3_done_fin", oFinished, 1);
        tick();
        check("t3_idle_busy", oBusy, 0);

        // continuous 0..2, three passes, continuous dropped during the third
        start_sweep(16'd0, 16'd2, 8'd1, 1'b1);
        for (int p = 1; p <= 3; p++) begin
            if (p == 3) iContinuous = 1'b0;
            for (int i = 0; i < 3; i++) begin
                check("t4_addr", oAddress, i);
                check("t4_strobe", oSampleStrobe, 1);
                tick();
            end
            check("t4_done_fin", oFinished, 1);
            check("t4_done_pass", oPassCount, p);
            tick();
        end
        check("t4_idle_busy", oBusy, 0);
        check("t4_idle_pass", oPassCount, 3);

        // abort on the fourth strobe
        start_sweep(16'd0, 16'h00FF, 8'd1, 1'b0);
        tick();
        tick();
        tick();
        check("t5_pre_addr", oAddress, 3);
        check("t5_pre_strobe", oSampleStrobe, 1);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        check("t5_ab_busy", oBusy, 0);
        check("t5_ab_fin", oFinished, 0);
        check("t5_ab_strobe", oSampleStrobe, 0);
        check("t5_ab_addr", oAddress, 3);
        check("t5_ab_pass", oPassCount, 0);
        tick();
        check("t5_ab_addr_frozen", oAddress, 3);
        check("t5_ab_fin_later", oFinished, 0);
        start_sweep(16'd7, 16'd7, 8'd1, 1'b0);
        check("t5_re_addr", oAddress, 7);
        check("t5_re_strobe", oSampleStrobe, 1);
        tick();
        check("t5_re_fin", oFinished, 1);
        check("t5_re_pass", oPassCount, 1);
        tick();

        // start ignored mid-sweep, then reset during HOLD
        start_sweep(16'h0020, 16'h0021, 8'd2, 1'b0);
        iStartAddr   = 16'h0050;
        iStartSignal = 1'b1;
        check("t6_addr0", oAddress, 16'h0020);
        tick();
        check("t6_hold_addr", oAddress, 16'h0020);
        check("t6_hold_strobe", oSampleStrobe, 0);
        tick();
        check("t6_addr1", oAddress, 16'h0021);
        check("t6_addr1_strobe", oSampleStrobe, 1);
        iStartSignal = 1'b0;
        tick();
        check("t6_hold2_busy", oBusy, 1);
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        check("t6_rst_addr", oAddress, 0);
        check("t6_rst_strobe", oSampleStrobe, 0);
        check("t6_rst_busy", oBusy, 0);
        check("t6_rst_fin", oFinished, 0);
        check("t6_rst_pass", oPassCount, 0);
        tick();
        check("t6_post_busy", oBusy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
